led_adc_sequencer: RTL and testbench
====================================

LED_ADC_SEQUENCER -- requirements
Module: led_adc_sequencer

Interface
REQ-001 Parameter PHASE_CYC, default 500, clock cycles per LED phase; 5 ms at 100 kHz, so IR/red alternate at 100 Hz.
REQ-002 Parameter SETTLE_CYC, default 100, cycles from LED turn-on to ADC start; legal only if SETTLE_CYC+2 <= PHASE_CYC.
REQ-003 Clocking: CLK_Filter, input, 1 bit, single clock, rising edge.
REQ-004 Reset: rst_n, input, 1 bit, synchronous, active-low.
REQ-005 En, input, 1 bit, run enable.
REQ-006 ADC_Done, input, 1 bit, one-cycle pulse: conversion complete.
REQ-007 ADC_Data, input, 8 bits, unsigned sample; valid while ADC_Done=1.
REQ-008 LED_IR and LED_Red, output, 1 bit each, registered LED drives; never both 1.
REQ-009 ADC_Start, output, 1 bit, one-cycle conversion request.
REQ-010 IR_ADC_Value and Red_ADC_Value, output, 8 bits each, latest samples feeding the FIR filters.
REQ-011 IR_Valid and Red_Valid, output, 1 bit each, one-cycle pulse: matching value just updated.
REQ-012 Sample_Miss, output, 1 bit, one-cycle pulse: a phase ended without ADC_Done.

Function
REQ-013 States SHALL be IDLE, IR_PH, RED_PH, plus DARK_PH when the REQ-029 macro is defined.
REQ-014 Phase counter SHALL run 0..PHASE_CYC-1 in every phase state and clear to 0 on each phase entry.
REQ-015 IDLE with En=1 SHALL enter IR_PH on the next edge with counter 0.
REQ-016 IDLE with En=0 SHALL stay IDLE.
REQ-017 At counter PHASE_CYC-1, IR_PH SHALL go to RED_PH; RED_PH SHALL go to DARK_PH when the macro is defined, else IR_PH; DARK_PH SHALL go to IR_PH.
REQ-018 LED_IR SHALL be 1 exactly while in IR_PH; LED_Red SHALL be 1 exactly while in RED_PH; both SHALL be 0 in IDLE and DARK_PH.
REQ-019 ADC_Start SHALL pulse for exactly one cycle when counter==SETTLE_CYC, once per phase.
REQ-020 ADC_Done SHALL be accepted only in the acceptance window, counter SETTLE_CYC+1..PHASE_CYC-1, and only for the first pulse in that phase.
REQ-021 ADC_Done outside the acceptance window, repeated pulses, and ADC_Done in IDLE SHALL be ignored.
REQ-022 On acceptance, the phase's value register SHALL load on the next edge, and IR_Valid or Red_Valid SHALL pulse in the same cycle the new value appears.
REQ-023 A done accepted at counter PHASE_CYC-1 SHALL still be credited to the phase it arrived in.
REQ-024 If a phase ends with no accepted done, Sample_Miss SHALL pulse in the first cycle of the next state, and the stale value SHALL be held with no Valid pulse.
REQ-025 En=0 in any phase SHALL force IDLE on the next edge: LEDs 0, counter 0, any in-flight conversion abandoned, values held, no Sample_Miss.
REQ-026 IR_Valid and Red_Valid SHALL never be 1 in the same cycle.

Reset
REQ-027 rst_n=0 at an edge SHALL set state IDLE and counter 0, and every output and internal register to 0, mid-phase included.
REQ-028 Reset SHALL take priority over En and ADC_Done.

Configuration
REQ-029 With macro AMBIENT_CANCEL_EN defined:
- DARK_PH (both LEDs off) SHALL be inserted, so a frame is 3*PHASE_CYC cycles.
- The accepted dark sample SHALL load an 8-bit ambient register, reset 0; no Valid pulse is issued for it.
- IR and Red values SHALL be max(raw-ambient, 0), using the ambient register contents at acceptance time.
REQ-030 Without AMBIENT_CANCEL_EN: 2-phase frame, raw samples passed through unmodified, no ambient register.

Verification (bench uses PHASE_CYC=20, SETTLE_CYC=5)
REQ-031 Reset then En=1: LED_IR high cycles 1-20, LED_Red high cycles 21-40, ADC_Start at phase counter 5 each phase, LEDs never overlap.
REQ-032 ADC_Done with ADC_Data=0x5A at IR counter 8: IR_ADC_Value=0x5A and IR_Valid=1 in one cycle only; second done at counter 12 ignored.
REQ-033 No ADC_Done during RED_PH: Sample_Miss pulses once at first IR_PH cycle, Red_ADC_Value unchanged, no Red_Valid.
REQ-034 ADC_Done at counter 5 and at counter 19: first ignored, second accepted; ADC_Done in IDLE ignored.
REQ-035 En dropped at RED counter 10 and rst_n pulsed mid-IR_PH: IDLE next edge, LEDs 0, no Sample_Miss; after reset all outputs 0.
REQ-036 With AMBIENT_CANCEL_EN, dark=0x20: IR raw 0x50 gives 0x30; Red raw 0x10 gives 0x00; frame length 60 cycles.

Source files
------------

// File: rtl/led_adc_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : led_adc_sequencer_if
// Description : Bundle of the LED/ADC sequencer's run control, ADC handshake,
//               LED drives and sample outputs.
//   master : drives En, ADC_Done, ADC_Data; observes every sequencer output
//   slave  : the sequencer itself
//   En            run enable
//   ADC_Done      one-cycle conversion-complete pulse, ADC_Data valid with it
//   LED_IR/Red    LED drives, never both high
//   ADC_Start     one-cycle conversion request
//   IR/Red_ADC_Value, IR/Red_Valid  latest samples and their update strobes
//   Sample_Miss   one-cycle pulse when a phase ended without a sample
// Revision    : 1.0 - initial release
// ============================================================================
interface led_adc_sequencer_if;
    logic       En;
    logic       ADC_Done;
    logic [7:0] ADC_Data;
    logic       LED_IR;
    logic       LED_Red;
    logic       ADC_Start;
    logic [7:0] IR_ADC_Value;
    logic [7:0] Red_ADC_Value;
    logic       IR_Valid;
    logic       Red_Valid;
    logic       Sample_Miss;

    modport master (
        output En, ADC_Done, ADC_Data,
        input  LED_IR, LED_Red, ADC_Start, IR_ADC_Value, Red_ADC_Value,
               IR_Valid, Red_Valid, Sample_Miss
    );

    modport slave (
        input  En, ADC_Done, ADC_Data,
        output LED_IR, LED_Red, ADC_Start, IR_ADC_Value, Red_ADC_Value,
               IR_Valid, Red_Valid, Sample_Miss
    );
endinterface
`default_nettype wire

// File: rtl/led_adc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : led_adc_sequencer
// Description : Alternates IR and red LED phases of PHASE_CYC cycles each,
//               requests one ADC conversion SETTLE_CYC cycles into every
//               phase and captures the first conversion that completes in
//               the phase's acceptance window. A phase with no captured
//               sample produces a Sample_Miss pulse and keeps the old value.
// Ports       : CLK_Filter  clock, rising edge
//               rst_n       synchronous active-low reset
//               bus         led_adc_sequencer_if.slave (En, ADC handshake,
//                           LED drives, sample values and strobes)
// Options     : AMBIENT_CANCEL_EN - adds a dark phase whose sample is
//               subtracted (floored at 0) from later IR and red samples.
// Revision    : 1.0 - initial release
// ============================================================================
module led_adc_sequencer #(
    parameter int PHASE_CYC  = 500,
    parameter int SETTLE_CYC = 100
) (
    input  wire logic          CLK_Filter,
    input  wire logic          rst_n,
    led_adc_sequencer_if.slave bus
);

    localparam int CNT_W = (PHASE_CYC > 1) ? $clog2(PHASE_CYC) : 1;
    localparam logic [CNT_W-1:0] C_LAST   = CNT_W'(PHASE_CYC - 1);
    localparam logic [CNT_W-1:0] C_SETTLE = CNT_W'(SETTLE_CYC);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_IR   = 2'd1;
    localparam logic [1:0] S_RED  = 2'd2;
`ifdef AMBIENT_CANCEL_EN
    localparam logic [1:0] S_DARK = 2'd3;
`endif

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_got;        // a sample was already taken this phase
    logic             r_led_ir;
    logic             r_led_red;
    logic             r_start;
    logic             r_miss;
    logic             r_ir_valid;
    logic             r_red_valid;
    logic [7:0]       r_ir_val;
    logic [7:0]       r_red_val;
`ifdef AMBIENT_CANCEL_EN
    logic [7:0]       r_ambient;
`endif

    logic             w_in_phase;
    logic             w_last;
    logic             w_accept;
    logic [1:0]       w_adv_state;
    logic [1:0]       w_next_state;
    logic [CNT_W-1:0] w_next_cnt;
    logic [7:0]       w_sample;

    always_comb begin
        w_in_phase = (r_state != S_IDLE);
        w_last     = w_in_phase && (r_cnt == C_LAST);
        // Window starts one cycle after the start request; the upper bound
        // is the phase's last count, so no explicit upper compare is needed.
        // A done arriving with En low is dropped with the abandoned phase.
        w_accept   = w_in_phase && bus.En && bus.ADC_Done && !r_got &&
                     (r_cnt > C_SETTLE);

        w_adv_state = S_IR;
        case (r_state)
            S_IR:    w_adv_state = S_RED;
`ifdef AMBIENT_CANCEL_EN
            S_RED:   w_adv_state = S_DARK;
`else
            S_RED:   w_adv_state = S_IR;
`endif
            default: w_adv_state = S_IR;
        endcase

        w_next_state = r_state;
        w_next_cnt   = r_cnt + 1'b1;
        if (!bus.En) begin
            w_next_state = S_IDLE;
            w_next_cnt   = '0;
        end else if (r_state == S_IDLE) begin
            w_next_state = S_IR;
            w_next_cnt   = '0;
        end else if (w_last) begin
            w_next_state = w_adv_state;
            w_next_cnt   = '0;
        end

`ifdef AMBIENT_CANCEL_EN
        w_sample = (bus.ADC_Data > r_ambient) ? (bus.ADC_Data - r_ambient) : 8'd0;
`else
        w_sample = bus.ADC_Data;
`endif
    end

    always_ff @(posedge CLK_Filter) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_got       <= 1'b0;
            r_led_ir    <= 1'b0;
            r_led_red   <= 1'b0;
            r_start     <= 1'b0;
            r_miss      <= 1'b0;
            r_ir_valid  <= 1'b0;
            r_red_valid <= 1'b0;
            r_ir_val    <= 8'd0;
            r_red_val   <= 8'd0;
`ifdef AMBIENT_CANCEL_EN
            r_ambient   <= 8'd0;
`endif
        end else begin
            r_state   <= w_next_state;
            r_cnt     <= w_next_cnt;
            // Cleared whenever the next cycle begins a fresh phase or idles.
            if (!bus.En || !w_in_phase || w_last)
                r_got <= 1'b0;
            else
                r_got <= r_got | w_accept;

            // Outputs are registered from next-state values so they line up
            // with the state they describe.
            r_led_ir  <= (w_next_state == S_IR);
            r_led_red <= (w_next_state == S_RED);
            r_start   <= (w_next_state != S_IDLE) && (w_next_cnt == C_SETTLE);

            // A done in the very last cycle still counts for this phase.
            r_miss      <= w_last && bus.En && !r_got && !w_accept;
            r_ir_valid  <= w_accept && (r_state == S_IR);
            r_red_valid <= w_accept && (r_state == S_RED);

            if (w_accept && (r_state == S_IR))
                r_ir_val <= w_sample;
            if (w_accept && (r_state == S_RED))
                r_red_val <= w_sample;
`ifdef AMBIENT_CANCEL_EN
            if (w_accept && (r_state == S_DARK))
                r_ambient <= bus.ADC_Data;
`endif
        end
    end

    assign bus.LED_IR        = r_led_ir;
    assign bus.LED_Red       = r_led_red;
    assign bus.ADC_Start     = r_start;
    assign bus.IR_ADC_Value  = r_ir_val;
    assign bus.Red_ADC_Value = r_red_val;
    assign bus.IR_Valid      = r_ir_valid;
    assign bus.Red_Valid     = r_red_valid;
    assign bus.Sample_Miss   = r_miss;

endmodule
`default_nettype wire

// File: tb/tb_led_adc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_adc_sequencer
// Description : Self-checking bench for led_adc_sequencer (PHASE_CYC=20,
//               SETTLE_CYC=5). A cycle-level reference model pushes the
//               expected outputs of every cycle into a queue; they are popped
//               and compared one cycle later. A table of ADC_Done injections
//               covers the acceptance window; hand-written sequences cover
//               En drop, mid-phase reset, idle done and ambient cancellation.
// Options     : AMBIENT_CANCEL_EN - follows the design's 3-phase variant.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_adc_sequencer;

    localparam int PHASE_CYC  = 20;
    localparam int SETTLE_CYC = 5;
`ifdef AMBIENT_CANCEL_EN
    localparam int NPH = 3;
`else
    localparam int NPH = 2;
`endif

    typedef struct packed {
        logic       led_ir;
        logic       led_red;
        logic       start;
        logic       ir_valid;
        logic       red_valid;
        logic       miss;
        logic [7:0] ir_val;
        logic [7:0] red_val;
    } obs_t;

    typedef struct {
        int         ph;     // phase index since enable
        int         cnt;    // phase counter at which ADC_Done is driven
        logic [7:0] data;
        logic       acc;    // expected to be accepted
        logic [7:0] val;    // expected value of that phase's register after
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    led_adc_sequencer_if bus ();

    led_adc_sequencer #(
        .PHASE_CYC  (PHASE_CYC),
        .SETTLE_CYC (SETTLE_CYC)
    ) dut (
        .CLK_Filter (clk),
        .rst_n      (rst_n),
        .bus        (bus)
    );

    int   total = 0;
    int   bad   = 0;
    obs_t exp_q[$];

    // Reference model state
    logic       m_idle = 1'b1;
    int         m_ph   = 0;   // 0 IR, 1 red, 2 dark
    int         m_k    = 0;
    logic       m_got  = 1'b0;
    logic [7:0] m_ir   = 8'd0;
    logic [7:0] m_red  = 8'd0;
    logic [7:0] m_amb  = 8'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic obs_t observe();
        obs_t o;
        o.led_ir    = bus.LED_IR;
        o.led_red   = bus.LED_Red;
        o.start     = bus.ADC_Start;
        o.ir_valid  = bus.IR_Valid;
        o.red_valid = bus.Red_Valid;
        o.miss      = bus.Sample_Miss;
        o.ir_val    = bus.IR_ADC_Value;
        o.red_val   = bus.Red_ADC_Value;
        return o;
    endfunction

    function automatic logic [7:0] cancel(input logic [7:0] raw, input logic [7:0] amb);
`ifdef AMBIENT_CANCEL_EN
        return (raw > amb) ? raw - amb : 8'd0;
`else
        return (amb == amb) ? raw : raw;
`endif
    endfunction

    // Drive one cycle of inputs, predict the outputs after the next edge,
    // then compare them.
    task automatic cycle(input logic rn, input logic en, input logic dn, input logic [7:0] d);
        obs_t e;
        obs_t a;
        logic acc;
        rst_n        = rn;
        bus.En       = en;
        bus.ADC_Done = dn;
        bus.ADC_Data = d;
        e = '0;
        if (!rn) begin
            m_idle = 1'b1; m_ph = 0; m_k = 0; m_got = 1'b0;
            m_ir = 8'd0; m_red = 8'd0; m_amb = 8'd0;
        end else if (m_idle) begin
            if (en) begin
                m_idle = 1'b0; m_ph = 0; m_k = 0; m_got = 1'b0;
            end
        end else if (!en) begin
            m_idle = 1'b1; m_k = 0; m_got = 1'b0;
        end else begin
            acc = dn && !m_got && (m_k > SETTLE_CYC) && (m_k <= PHASE_CYC - 1);
            if (acc) begin
                if (m_ph == 0) begin m_ir  = cancel(d, m_amb); e.ir_valid  = 1'b1; end
                if (m_ph == 1) begin m_red = cancel(d, m_amb); e.red_valid = 1'b1; end
                if (m_ph == 2) m_amb = d;
            end
            if (m_k == PHASE_CYC - 1) begin
                e.miss = !(m_got || acc);
                m_ph   = (m_ph + 1) % NPH;
                m_k    = 0;
                m_got  = 1'b0;
            end else begin
                m_k++;
                m_got = m_got | acc;
            end
        end
        e.ir_val  = m_ir;
        e.red_val = m_red;
        if (!m_idle) begin
            e.led_ir  = (m_ph == 0);
            e.led_red = (m_ph == 1);
            e.start   = (m_k == SETTLE_CYC);
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        a = observe();
        if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL scoreboard_empty: got 0 entries expected 1");
        end else begin
            chk("cycle_outputs", 32'(a), 32'(exp_q.pop_front()));
        end
        // LEDs must never be on together, whatever the model says.
        chk("led_overlap", {31'd0, a.led_ir & a.led_red}, 32'd0);
        chk("valid_overlap", {31'd0, a.ir_valid & a.red_valid}, 32'd0);
    endtask

    vec_t vecs[8];
    int   misses;
    int   hit;
    int   kind;

    initial begin
        vecs[0] = '{ph: 0, cnt:  8, data: 8'h5A, acc: 1'b1, val: 8'h5A};
        vecs[1] = '{ph: 0, cnt: 12, data: 8'h77, acc: 1'b0, val: 8'h5A};
        vecs[2] = '{ph: 1, cnt:  5, data: 8'h33, acc: 1'b0, val: 8'h00};
        vecs[3] = '{ph: 1, cnt: 19, data: 8'h44, acc: 1'b1, val: 8'h44};
        vecs[4] = '{ph: 2, cnt:  6, data: 8'h11, acc: 1'b1, val: 8'h11};
        vecs[5] = '{ph: 4, cnt:  0, data: 8'h99, acc: 1'b0, val: 8'h11};
        vecs[6] = '{ph: 4, cnt: 10, data: 8'h22, acc: 1'b1, val: 8'h22};
        vecs[7] = '{ph: 5, cnt: 15, data: 8'h66, acc: 1'b1, val: 8'h66};

        rst_n = 1'b0; bus.En = 1'b0; bus.ADC_Done = 1'b0; bus.ADC_Data = 8'h00;

        // Reset state
        cycle(1'b0, 1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b1, 1'b1, 8'hAB);
        chk("reset_outputs", 32'(observe()), 32'd0);

        // Table-driven run: six phases from enable, phase 3 gets no sample
        misses = 0;
        cycle(1'b1, 1'b1, 1'b0, 8'h00);
        chk("first_cycle_led_ir", {31'd0, bus.LED_IR}, 32'd1);
        for (int j = 0; j < 6; j++) begin
            for (int c = 0; c < PHASE_CYC; c++) begin
                hit = -1;
                for (int i = 0; i < 8; i++)
                    if (vecs[i].ph == j && vecs[i].cnt == c) hit = i;
                if (hit >= 0) cycle(1'b1, 1'b1, 1'b1, vecs[hit].data);
                else          cycle(1'b1, 1'b1, 1'b0, 8'h00);
                if (bus.Sample_Miss) misses++;
                if (hit >= 0) begin
                    kind = j % NPH;
                    if (kind == 0)      chk("vec_ir_valid",  {31'd0, bus.IR_Valid},  {31'd0, vecs[hit].acc});
                    else if (kind == 1) chk("vec_red_valid", {31'd0, bus.Red_Valid}, {31'd0, vecs[hit].acc});
                    else                chk("vec_dark_valid", {30'd0, bus.IR_Valid, bus.Red_Valid}, 32'd0);
`ifndef AMBIENT_CANCEL_EN
                    if (kind == 0) chk("vec_ir_value",  {24'd0, bus.IR_ADC_Value},  {24'd0, vecs[hit].val});
                    else           chk("vec_red_value", {24'd0, bus.Red_ADC_Value}, {24'd0, vecs[hit].val});
`endif
                end
            end
        end
        chk("miss_count", 32'(misses), 32'd1);

        // En dropped at red counter 10, then a done while idle
        cycle(1'b0, 1'b0, 1'b0, 8'h00);
        cycle(1'b1, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < PHASE_CYC + 10; i++) cycle(1'b1, 1'b1, 1'b0, 8'h00);
        chk("at_red_cnt10", {30'd0, bus.LED_IR, bus.LED_Red}, 32'd1);
        cycle(1'b1, 1'b0, 1'b0, 8'h00);
        chk("en_drop_idle", {29'd0, bus.LED_IR, bus.LED_Red, bus.Sample_Miss}, 32'd0);
        cycle(1'b1, 1'b0, 1'b1, 8'hEE);
        chk("idle_done_ignored", {30'd0, bus.IR_Valid, bus.Red_Valid}, 32'd0);
        cycle(1'b1, 1'b0, 1'b0, 8'h00);

        // Reset mid IR phase after a sample was taken
        cycle(1'b1, 1'b1, 1'b0, 8'h00);
        for (int c = 0; c < 8; c++) cycle(1'b1, 1'b1, 1'b0, 8'h00);
        cycle(1'b1, 1'b1, 1'b1, 8'h3C);
        chk("pre_reset_ir_value", {24'd0, bus.IR_ADC_Value}, 32'h3C);
        cycle(1'b1, 1'b1, 1'b0, 8'h00);
        cycle(1'b0, 1'b1, 1'b1, 8'h12);
        chk("mid_reset_outputs", 32'(observe()), 32'd0);
        cycle(1'b1, 1'b0, 1'b0, 8'h00);

`ifdef AMBIENT_CANCEL_EN
        // Dark sample 0x20, then IR 0x50 -> 0x30 and red 0x10 -> 0x00
        cycle(1'b1, 1'b1, 1'b0, 8'h00);
        for (int j = 0; j < 5; j++) begin
            for (int c = 0; c < PHASE_CYC; c++) begin
                if (c == 8 && j == 2)      cycle(1'b1, 1'b1, 1'b1, 8'h20);
                else if (c == 8 && j == 3) cycle(1'b1, 1'b1, 1'b1, 8'h50);
                else if (c == 8 && j == 4) cycle(1'b1, 1'b1, 1'b1, 8'h10);
                else                       cycle(1'b1, 1'b1, 1'b0, 8'h00);
                if (c == 8 && j == 3) chk("ambient_ir",  {24'd0, bus.IR_ADC_Value},  32'h30);
                if (c == 8 && j == 4) chk("ambient_red", {23'd0, bus.Red_Valid, bus.Red_ADC_Value}, 32'h100);
            end
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
